// File: rtl/uart_rx_dispatch.sv
// Receive-side dispatcher: parses a one-byte header and routes payload bytes to channels via a shared FWFT FIFO.
// Optional idle timeout in PAYLOAD is enabled by defining RX_TIMEOUT_EN.
module uart_rx_dispatch #(
  parameter int WORD_LENGTH = 8,
  parameter int NUM_CH      = 4,
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                   r_clk,
  input  logic                   r_rst,
  input  logic                   rx_valid,
  input  logic [WORD_LENGTH-1:0] rx_data,
  input  logic                   rx_err,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2:0]             out_ch,
  output logic [WORD_LENGTH-1:0] out_data,
  output logic                   out_last,
  output logic                   out_err,
  output logic                   busy,
  output logic [7:0]             err_cnt,
  output logic [7:0]             drop_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 3 + WORD_LENGTH + 2;
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_PAYLOAD = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [4:0]      rem_q, rem_d;
  logic [2:0]      ch_q, ch_d;
  logic [7:0]      err_cnt_q, drop_cnt_q;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q;
  logic [EW-1:0]   mem_q [FIFO_DEPTH];

  logic            hdr_ok_s, timeout_s, push_req_s, push_s, pop_s, room_s, err_inc_s;
  logic [EW-1:0]   entry_s, head_s;

  assign hdr_ok_s = ({1'b0, rx_data[2:0]} < 4'(NUM_CH)) && !rx_data[3] && !rx_err;

`ifdef RX_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT_CYC + 1);
  logic [IW-1:0] idle_q;

  // Idle counter: cleared outside PAYLOAD, reloaded by every received byte.
  always_ff @(posedge r_clk) begin
    if (r_rst || state_q != ST_PAYLOAD || rx_valid) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_q + IW'(1);
    end
  end

  // Fires on the TIMEOUT_CYC-th consecutive silent cycle; a byte in that cycle wins.
  assign timeout_s = (state_q == ST_PAYLOAD) && !rx_valid && (idle_q == IW'(TIMEOUT_CYC - 1));
`else
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT_CYC == 0);
  assign timeout_s      = 1'b0;
`endif

  // State register
  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (rx_valid && hdr_ok_s) state_d = ST_PAYLOAD;
        else                      state_d = ST_IDLE;
      end
      ST_PAYLOAD: begin
        if (rx_valid) begin
          if (rx_err || rem_q == 5'd1) state_d = ST_IDLE;
          else                         state_d = ST_PAYLOAD;
        end else if (timeout_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_PAYLOAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output/datapath decode: push requests, error events, frame bookkeeping
  always_comb begin
    push_req_s = 1'b0;
    entry_s    = '0;
    err_inc_s  = 1'b0;
    rem_d      = rem_q;
    ch_d       = ch_q;
    case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          if (hdr_ok_s) begin
            ch_d  = rx_data[2:0];
            rem_d = {1'b0, rx_data[7:4]} + 5'd1;
          end else begin
            err_inc_s = 1'b1;
          end
        end else begin
          rem_d = rem_q;
        end
      end
      ST_PAYLOAD: begin
        if (rx_valid) begin
          push_req_s = 1'b1;
          if (rx_err) begin
            err_inc_s = 1'b1;
            entry_s   = {ch_q, {WORD_LENGTH{1'b0}}, 1'b1, 1'b1};
          end else begin
            entry_s = {ch_q, rx_data, (rem_q == 5'd1), 1'b0};
            rem_d   = rem_q - 5'd1;
          end
        end else if (timeout_s) begin
          push_req_s = 1'b1;
          err_inc_s  = 1'b1;
          entry_s    = {ch_q, {WORD_LENGTH{1'b0}}, 1'b1, 1'b1};
        end else begin
          push_req_s = 1'b0;
        end
      end
      default: begin
        push_req_s = 1'b0;
      end
    endcase
  end

  assign pop_s  = out_valid && out_ready;
  assign room_s = (count_q != CNT_FULL) || pop_s;
  assign push_s = push_req_s && room_s;

  // Frame registers, statistics, FIFO pointers and occupancy
  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      rem_q      <= 5'd0;
      ch_q       <= 3'd0;
      err_cnt_q  <= 8'd0;
      drop_cnt_q <= 8'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      rem_q <= rem_d;
      ch_q  <= ch_d;
      if (err_inc_s && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
      if (push_req_s && !room_s && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
      if (push_s) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_s)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage; contents are don't-care while not counted as valid
  always_ff @(posedge r_clk) begin
    if (push_s) mem_q[wr_ptr_q] <= entry_s;
  end

  assign head_s    = mem_q[rd_ptr_q];
  assign out_valid = (count_q != '0);
  assign out_ch    = out_valid ? head_s[EW-1 -: 3] : 3'd0;
  assign out_data  = out_valid ? head_s[WORD_LENGTH+1:2] : {WORD_LENGTH{1'b0}};
  assign out_last  = out_valid && head_s[1];
  assign out_err   = out_valid && head_s[0];
  assign busy      = (state_q != ST_IDLE);
  assign err_cnt   = err_cnt_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: doc/uart_rx_dispatch.md
Name: uart_rx_dispatch

Overview:
- Receive-side scheduler behind the UART receiver: takes the byte stream (one strobe per received byte plus an error qualifier), parses a one-byte header, and routes the following payload bytes to one of NUM_CH consumer channels through a shared FIFO with a valid/ready handshake.
- Also terminates errored or truncated frames and keeps saturating error and drop statistics.

Parameters:
- WORD_LENGTH, 8, bits per received byte; fixed at 8 (the header format depends on it).
- NUM_CH, 4, number of consumer channels; 1..8.
- FIFO_DEPTH, 8, entries in the shared output FIFO; power of 2, at least 2.
- TIMEOUT_CYC, 4096, idle cycles allowed between payload bytes; used only with RX_TIMEOUT_EN.

Ports:
- r_clk  in  1  clock.
- r_rst  in  1  reset, synchronous, active-high.
- rx_valid  in  1  one-cycle strobe: a byte was received.
- rx_data  in  WORD_LENGTH  received byte; sampled only when rx_valid=1.
- rx_err  in  1  parity or stop error for this byte; sampled only when rx_valid=1.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  consumer accepts the head.
- out_ch  out  3  destination channel of the head entry.
- out_data  out  WORD_LENGTH  payload byte.
- out_last  out  1  last entry of the frame.
- out_err  out  1  frame-abort marker (data is 0x00, last=1).
- busy  out  1  state != IDLE.
- err_cnt  out  8  saturating count of error and abort events.
- drop_cnt  out  8  saturating count of bytes dropped because the FIFO was full.

Behaviour:
- Reset (synchronous, r_rst=1 at a r_clk edge): state=IDLE, FIFO empty, out_valid=0, out_ch/out_data/out_last/out_err=0, busy=0, err_cnt=0, drop_cnt=0, remaining-length counter=0.
- Header format: hdr[2:0] = channel, hdr[3] = reserved (must be 0), hdr[7:4] = payload length minus 1 (1..16 bytes).
- Header is invalid if any of these holds: channel >= NUM_CH, hdr[3]=1, or rx_err=1.
- States and transitions:
  - IDLE, on rx_valid:
    - Valid header: latch channel, remaining = hdr[7:4]+1, go to PAYLOAD.
    - Invalid header: err_cnt+1, stay in IDLE. Nothing is pushed.
  - PAYLOAD, on rx_valid with rx_err=0: push {ch, data, last=(remaining==1), err=0}, decrement remaining. When last is pushed, go to IDLE.
  - PAYLOAD, on rx_valid with rx_err=1: byte is not stored, err_cnt+1, push abort marker {ch, 0x00, last=1, err=1}, go to IDLE.
  - rx_valid=0: no state change (except for the timeout below).
- Push rules:
  - Push is allowed if count < FIFO_DEPTH, or if a pop happens in the same cycle.
  - Payload byte with no room: dropped, drop_cnt+1. remaining still decrements. If it was the last byte, the state still returns to IDLE, and that frame has no last entry.
  - Abort marker with no room: dropped, drop_cnt+1.
- Pop: when out_valid & out_ready. Outputs are first-word-fallthrough from the FIFO head.
- out_valid=1 whenever count>0. Head fields stay stable while out_valid=1 and out_ready=0.
- Push into an empty FIFO: out_valid=1 on the next cycle (latency 1 from rx_valid).
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count is log2(FIFO_DEPTH)+1 bits.
- Counters: err_cnt and drop_cnt hold at 255 (no wrap). If both increment in the same cycle, each is updated independently.
- Reset mid-frame: the frame is discarded and the FIFO contents are lost. No abort marker is emitted.
- busy=1 in PAYLOAD (and in any other non-IDLE state).

Optional Feature:
- Macro: RX_TIMEOUT_EN.
- Defined:
  - In PAYLOAD, an idle counter reloads on every rx_valid and increments otherwise.
  - When it reaches TIMEOUT_CYC with no byte received: err_cnt+1, push abort marker {ch, 0x00, 1, 1} (same full-FIFO rule as above), go to IDLE.
  - The counter is cleared in IDLE.
  - If rx_valid arrives in the same cycle the counter hits TIMEOUT_CYC, the byte wins and no timeout fires.
- Not defined: no idle counter. PAYLOAD waits indefinitely; TIMEOUT_CYC is unused.

Test Plan:
- Header 0x21 then bytes 0xA5,0x5A,0x3C, out_ready=1 -> three pops on ch1: data A5/5A/3C, last=0,0,1, err=0. Then busy=0, err_cnt=0.
- Header 0x03 with NUM_CH=4, then header 0x0B -> ch3 frame delivered with 1 byte. The 0x0B header (reserved bit set) is rejected: err_cnt=1, nothing pushed.
- Header 0x22, byte 0x11, then byte with rx_err=1 -> pops: {ch2,0x11,last0,err0}, {ch2,0x00,last1,err1}. err_cnt=1, state=IDLE.
- FIFO_DEPTH=8, out_ready=0, header 0xF0 then 16 bytes -> 8 entries stored, drop_cnt=8, out_valid=1 with head stable. Raise out_ready, then deliver 8 more pushes, each in the same cycle as a pop -> no further drops.
- r_rst asserted for one cycle mid-PAYLOAD with 2 entries queued -> next cycle: out_valid=0, busy=0, counters=0. The next header is parsed normally.
- RX_TIMEOUT_EN, TIMEOUT_CYC=16: header 0x10, one byte, then silence -> after 16 idle cycles an abort marker {ch0,0x00,1,1} is pushed, err_cnt=1. A byte arriving at cycle 16 suppresses the abort.
